// File: rtl/key_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_uart_pkg
// Purpose  : Shared types, constants and helpers for the keypad UART sender.
//            Optional feature macro: UART_PARITY_EN (even parity bit).
// Revision : 1.0 - initial release
// ============================================================================
package key_uart_pkg;

  // Transmit FSM states; PARITY is only reachable with UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Scanner output meaning "no key pressed yet"
  localparam logic [7:0] ASCII_NUL = 8'h00;

  // Clock cycles per UART bit, integer-truncated
  function automatic int div_calc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : key_uart_tx_if
// Purpose  : Key input and UART/status outputs of the keypad UART sender.
//            Optional feature macro: UART_PARITY_EN (no effect on this file).
// Revision : 1.0 - initial release
// ============================================================================
interface key_uart_tx_if;
  logic [7:0] key_val;
  logic       tx;
  logic       busy;
  logic       key_push;
  logic       overflow;

  // The sender consumes key_val and drives everything else
  modport slave  (input key_val, output tx, busy, key_push, overflow);
  // The environment (scanner side / bench) drives key_val
  modport master (output key_val, input tx, busy, key_push, overflow);
endinterface
`default_nettype wire

// File: rtl/key_uart_tx_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Purpose  : Single-byte UART transmitter with valid/ready handshake.
//            8 data bits LSB first, 1 stop bit; even parity bit added
//            when UART_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_tx
  import key_uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [7:0] i_data,
  input  wire logic       i_valid,
  output logic            o_ready,
  output logic            o_tx,
  output logic            o_busy
);

  localparam int             c_BW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(DIV - 1);

  localparam logic [2:0] c_S_IDLE   = IDLE;
  localparam logic [2:0] c_S_START  = START;
  localparam logic [2:0] c_S_DATA   = DATA;
`ifdef UART_PARITY_EN
  localparam logic [2:0] c_S_PARITY = PARITY;
`endif
  localparam logic [2:0] c_S_STOP   = STOP;

  logic [2:0]      r_state;
  logic [c_BW-1:0] r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
`ifdef UART_PARITY_EN
  logic            r_par;
`endif
  logic            w_bit_end;

  assign w_bit_end = (r_baud == c_BAUD_LAST);

  // FSM, baud counter and shift register; baud counter restarts on every state entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (i_valid) begin
            r_state <= c_S_START;
            r_shift <= i_data;
`ifdef UART_PARITY_EN
            r_par   <= ^i_data;
`endif
            r_baud  <= '0;
            r_bit   <= '0;
          end
        end
        c_S_START: begin
          if (w_bit_end) begin
            r_state <= c_S_DATA;
            r_baud  <= '0;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        c_S_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= c_S_PARITY;
`else
              r_state <= c_S_STOP;
`endif
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        c_S_PARITY: begin
          if (w_bit_end) begin
            r_state <= c_S_STOP;
            r_baud  <= '0;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        c_S_STOP: begin
          if (w_bit_end) begin
            r_state <= c_S_IDLE;
            r_baud  <= '0;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= c_S_IDLE;
          r_baud  <= '0;
        end
      endcase
    end
  end

  // Line level is a pure decode of state, so reset forces idle-high at once
  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      c_S_START:  o_tx = 1'b0;
      c_S_DATA:   o_tx = r_shift[0];
`ifdef UART_PARITY_EN
      c_S_PARITY: o_tx = r_par;
`endif
      default:    o_tx = 1'b1;
    endcase
  end

  assign o_ready = (r_state == c_S_IDLE);
  assign o_busy  = ~o_ready;

endmodule
`default_nettype wire

// File: rtl/key_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : key_uart_tx
// Purpose  : Sends each new, stable keypad ASCII code once over a UART line,
//            buffering key events in a small FIFO while a frame is sent.
//            Optional feature macro: UART_PARITY_EN (8E1 instead of 8N1).
// Revision : 1.0 - initial release
// ============================================================================
module key_uart_tx
  import key_uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 115_200,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  key_uart_tx_if.slave bus
);

  localparam int c_DIV = div_calc(CLK_FREQ, BAUD);
  localparam int c_SCW = $clog2(STABLE_CYCLES + 1);
  localparam int c_AW  = $clog2(FIFO_DEPTH);
  localparam int c_CW  = c_AW + 1;

  localparam logic [c_SCW-1:0] c_STAB_MAX  = c_SCW'(STABLE_CYCLES);
  localparam logic [c_SCW-1:0] c_STAB_LAST = c_SCW'(STABLE_CYCLES - 1);
  localparam logic [c_CW-1:0]  c_FULL      = c_CW'(FIFO_DEPTH);

  // Detector state
  logic [7:0]       r_key_q;
  logic [c_SCW-1:0] r_stab_cnt;
  logic [7:0]       r_last_sent;

  // FIFO state
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;

  logic             r_key_push;
  logic             r_overflow;

  logic             w_same;
  logic             w_push_req;
  logic             w_full;
  logic             w_empty;
  logic             w_ready;
  logic             w_pop;
  logic             w_push;
  logic             w_tx;
  logic             w_busy;
  logic [7:0]       w_rd_data;

  // The counter reaches STABLE_CYCLES on this edge exactly when it is one short now
  assign w_same     = (bus.key_val == r_key_q);
  assign w_push_req = w_same && (r_stab_cnt == c_STAB_LAST) &&
                      (r_key_q != ASCII_NUL) && (r_key_q != r_last_sent);

  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign w_pop     = ~w_empty & w_ready;
  // A pop in the same cycle frees the slot the push will use
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_rd_data = r_mem[r_rd_ptr];

  // Input register and saturating stability counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_q    <= ASCII_NUL;
      r_stab_cnt <= '0;
    end else begin
      r_key_q <= bus.key_val;
      if (!w_same) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != c_STAB_MAX) begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  // Event bookkeeping; a dropped event still counts as sent so it is not retried
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_sent <= ASCII_NUL;
      r_key_push  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_key_push <= w_push;
      r_overflow <= w_push_req & ~w_push;
      if (w_push_req) begin
        r_last_sent <= r_key_q;
      end
    end
  end

  // FIFO storage; contents are don't-care while the occupancy says empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_key_q;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  uart_byte_tx #(
    .DIV (c_DIV)
  ) u_byte_tx (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_rd_data),
    .i_valid (~w_empty),
    .o_ready (w_ready),
    .o_tx    (w_tx),
    .o_busy  (w_busy)
  );

  assign bus.tx       = w_tx;
  assign bus.busy     = w_busy;
  assign bus.key_push = r_key_push;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_uart_tx
// Purpose  : Directed self-checking bench for key_uart_tx with an
//            independent UART receiver model. Honours UART_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_uart_tx;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int DIV = 10;

  logic clk;
  logic rst;
  key_uart_tx_if bus ();

  key_uart_tx #(
    .CLK_FREQ      (1000),
    .BAUD          (100),
    .STABLE_CYCLES (20),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Event counters and busy-length monitor
  int push_cnt = 0;
  int ovf_cnt  = 0;
  int busy_run = 0;
  int busy_len_last = 0;
  always @(negedge clk) begin
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (bus.key_push === 1'b1) push_cnt++;
      if (bus.overflow === 1'b1) ovf_cnt++;
      if (bus.busy === 1'b1) begin
        busy_run++;
      end else if (busy_run != 0) begin
        busy_len_last = busy_run;
        busy_run = 0;
      end
    end
  end

  // UART receiver model: samples mid-bit, aborts on reset
  logic [7:0] rx_q [$];
  logic       par_q [$];
  int         frame_err = 0;
  bit         rx_act = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;
  logic       rx_par;
  always @(negedge clk) begin
    if (!rst) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (bus.tx === 1'b0) begin
        rx_act = 1;
        rx_cnt = 0;
        rx_par = 1'b0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2) begin
        if (rx_cnt / DIV == NB - 1) begin
          if (bus.tx !== 1'b1) frame_err++;
          rx_q.push_back(rx_byte);
          par_q.push_back(rx_par);
          rx_act = 0;
        end else if (rx_cnt / DIV == 0) begin
          if (bus.tx !== 1'b0) frame_err++;
        end else if (rx_cnt / DIV <= 8) begin
          rx_byte[rx_cnt / DIV - 1] = bus.tx;
        end else begin
          rx_par = bus.tx;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) until n frames have been received, then compare the count
  task automatic wait_rx(input string tag, input int n);
    for (int i = 0; i < 1500; i++) begin
      if (rx_q.size() >= n) break;
      @(negedge clk);
    end
    check(tag, rx_q.size(), n);
  endtask

  int  lat;
  bit  flag;
  int  base;

  initial begin
    rst = 1'b0;
    bus.key_val = 8'h00;

    // 1. reset state and idle line
    repeat (5) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_push", bus.key_push, 0);
    check("rst_ovf", bus.overflow, 0);
    rst = 1'b1;
    flag = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.key_push !== 1'b0 || bus.overflow !== 1'b0)
        flag = 1;
    end
    check("idle_quiet", flag, 0);

    // 2. first key 0x35: push latency, start bit, data and frame length
    bus.key_val = 8'h35;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.key_push === 1'b1) begin
        lat = i;
        break;
      end
      check("pre_push_tx", bus.tx, 1);
    end
    check("push_latency", lat, 21);
    @(negedge clk);
    check("start_tx", bus.tx, 0);
    check("start_busy", bus.busy, 1);
    wait_rx("frame1_cnt", 1);
    repeat (10) @(negedge clk);
    check("frame1_byte", rx_q[0], 8'h35);
    check("frame1_busy_len", busy_len_last, NB * DIV);
    check("push_cnt_2", push_cnt, 1);

    // 3. short glitch to 0x36, then back to the already-sent 0x35
    bus.key_val = 8'h36;
    repeat (15) @(negedge clk);
    bus.key_val = 8'h35;
    flag = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) flag = 1;
    end
    check("glitch_push", push_cnt, 1);
    check("glitch_frames", rx_q.size(), 1);
    check("glitch_busy", flag, 0);

    // 4. seven keys 25 cycles apart: FIFO fills, last one overflows
    for (int k = 0; k < 7; k++) begin
      bus.key_val = 8'h41 + 8'(k);
      repeat (25) @(negedge clk);
    end
    wait_rx("burst_cnt", 7);
    repeat (20) @(negedge clk);
    check("burst_push", push_cnt, 7);
    check("burst_ovf", ovf_cnt, 1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("burst_byte%0d", k), rx_q[1 + k], 8'h41 + 8'(k));
    end

    // 5. key 0x31: bit order, parity (if enabled) and frame length
    bus.key_val = 8'h31;
    wait_rx("k31_cnt", 8);
    repeat (10) @(negedge clk);
    check("k31_byte", rx_q[7], 8'h31);
    check("k31_busy_len", busy_len_last, NB * DIV);
`ifdef UART_PARITY_EN
    check("k31_parity", par_q[7], 1);
`endif

    // 6. reset in the middle of data bit 4 with one key waiting in the FIFO
    base = push_cnt;
    bus.key_val = 8'h32;
    flag = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        flag = 0;
        break;
      end
    end
    check("k32_start_seen", flag, 0);
    bus.key_val = 8'h33;
    repeat (54) @(negedge clk);
    check("k33_queued", push_cnt, base + 2);
    check("mid_busy", bus.busy, 1);
    #1 rst = 1'b0;
    bus.key_val = 8'h00;
    #1;
    check("async_tx", bus.tx, 1);
    check("async_busy", bus.busy, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    flag = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) flag = 1;
    end
    check("post_rst_quiet", flag, 0);
    check("post_rst_frames", rx_q.size(), 8);
    check("post_rst_push", push_cnt, base + 2);
    bus.key_val = 8'h34;
    wait_rx("k34_cnt", 9);
    check("k34_byte", rx_q[8], 8'h34);
    check("frame_err", frame_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
